// File: rtl/sysbus_arb_pkg.sv
// Shared types and helpers for the Sysbus requester arbiter.
package sysbus_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAddr  = 2'd1,
    StWdata = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  // Value of the tag direction bit that marks a write transaction.
  localparam logic SYSBUS_WRITE = 1'b1;

  localparam int unsigned DEFAULT_TAG_WIDTH = 13;
  localparam int unsigned TAG_DIR_BIT       = DEFAULT_TAG_WIDTH - 1;

  function automatic int unsigned tag_dir_bit(input int unsigned tag_width);
    return tag_width - 1;
  endfunction

  function automatic int unsigned beat_cnt_width(input int unsigned resp_beats,
                                                 input int unsigned write_beats);
    int unsigned max_beats;
    max_beats = (resp_beats > write_beats) ? resp_beats : write_beats;
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/sysbus_arbiter_if.sv
// Requester-side and bus-side Sysbus signals shared by the arbiter and its environment.
interface sysbus_arbiter_if #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned NUM_REQ        = 3
);

  logic [NUM_REQ-1:0]                rq_reqcyc;
  logic [NUM_REQ*BUS_DATA_WIDTH-1:0] rq_req;
  logic [NUM_REQ*BUS_TAG_WIDTH-1:0]  rq_reqtag;
  logic [NUM_REQ-1:0]                rq_reqack;
  logic [NUM_REQ-1:0]                rq_respcyc;
  logic [BUS_DATA_WIDTH-1:0]         rq_resp;
  logic [BUS_TAG_WIDTH-1:0]          rq_resptag;
  logic [NUM_REQ-1:0]                rq_respack;

  logic                              bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0]         bus_req;
  logic [BUS_TAG_WIDTH-1:0]          bus_reqtag;
  logic                              bus_reqack;
  logic                              bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0]         bus_resp;
  logic [BUS_TAG_WIDTH-1:0]          bus_resptag;
  logic                              bus_respack;

  // Arbiter view.
  modport slave (
    input  rq_reqcyc, rq_req, rq_reqtag, rq_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output rq_reqack, rq_respcyc, rq_resp, rq_resptag,
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

  // Requesters plus bus, seen from outside the arbiter.
  modport master (
    output rq_reqcyc, rq_req, rq_reqtag, rq_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  rq_reqack, rq_respcyc, rq_resp, rq_resptag,
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   winner,
  output logic [IDX_WIDTH-1:0] winner_idx,
  output logic                 valid
);

  int unsigned idx;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    idx        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid       = 1'b1;
        winner[idx] = 1'b1;
        winner_idx  = IDX_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// Round-robin owner of the single Sysbus port; grant is held for a whole transaction and
// the grantee is muxed onto the bus with responses routed back to it alone.
module sysbus_arbiter
  import sysbus_arb_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned RESP_BEATS     = 8,
  parameter int unsigned WRITE_BEATS    = 8
) (
  input  logic               clk,
  input  logic               reset,
  sysbus_arbiter_if.slave    sb,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy
);

  localparam int unsigned IdxWidth = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntWidth = beat_cnt_width(RESP_BEATS, WRITE_BEATS);
  localparam int unsigned DirBit   = tag_dir_bit(BUS_TAG_WIDTH);

  arb_state_e            state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [IdxWidth-1:0]   gidx_q, gidx_d;
  logic [IdxWidth-1:0]   ptr_q, ptr_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  is_write_q, is_write_d;

  logic [NUM_REQ-1:0]    win_onehot;
  logic [IdxWidth-1:0]   win_idx;
  logic                  win_valid;
  logic [IdxWidth-1:0]   next_ptr;
  logic                  req_beat, resp_beat, done;

  logic [BUS_DATA_WIDTH-1:0] req_data [NUM_REQ];
  logic [BUS_TAG_WIDTH-1:0]  req_tag  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data[i] = sb.rq_req[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    assign req_tag[i]  = sb.rq_reqtag[i*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IdxWidth)
  ) u_rr (
    .req        (sb.rq_reqcyc),
    .ptr        (ptr_q),
    .winner     (win_onehot),
    .winner_idx (win_idx),
    .valid      (win_valid)
  );

  assign next_ptr      = (gidx_q == IdxWidth'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
  assign sb.rq_resp    = sb.bus_resp;
  assign sb.rq_resptag = sb.bus_resptag;
  assign grant         = grant_q;
  assign busy          = (state_q != StIdle);

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    gidx_d         = gidx_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    is_write_d     = is_write_q;
    sb.bus_reqcyc  = 1'b0;
    sb.bus_req     = '0;
    sb.bus_reqtag  = '0;
    sb.bus_respack = 1'b0;
    sb.rq_reqack   = '0;
    sb.rq_respcyc  = '0;
    done           = 1'b0;

    if (state_q != StIdle) begin
      sb.bus_reqcyc = sb.rq_reqcyc[gidx_q];
      sb.bus_req    = req_data[gidx_q];
      sb.bus_reqtag = req_tag[gidx_q];
      sb.rq_reqack  = grant_q & {NUM_REQ{sb.bus_reqack}};
      sb.rq_respcyc = grant_q & {NUM_REQ{sb.bus_respcyc}};
      // Response beats outside the response phase are left unacknowledged.
      if (state_q == StResp) sb.bus_respack = sb.rq_respack[gidx_q];
    end

    req_beat  = sb.bus_reqcyc & sb.bus_reqack;
    resp_beat = sb.bus_respcyc & sb.bus_respack;

    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d    = StAddr;
          grant_d    = win_onehot;
          gidx_d     = win_idx;
          is_write_d = (req_tag[win_idx][DirBit] == SYSBUS_WRITE);
        end
      end
      StAddr: begin
        if (!sb.bus_reqcyc) begin
          done = 1'b1;
        end else if (req_beat) begin
          state_d = is_write_q ? StWdata : StResp;
          cnt_d   = '0;
        end
      end
      StWdata: begin
        if (req_beat) begin
          if (cnt_q == CntWidth'(WRITE_BEATS - 1)) done = 1'b1;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (resp_beat) begin
          if (cnt_q == CntWidth'(RESP_BEATS - 1)) done = 1'b1;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (done) begin
      state_d = StIdle;
      grant_d = '0;
      ptr_d   = next_ptr;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
    end
  end

endmodule
